lane_update_sequencer: RTL and testbench

- Time-multiplexed element-wise evaluator. It is the sequential counterpart to a parallel, per-lane combinational `c[i] = f(x[i])`.
- Tracks which input lanes have changed and issues one request per lane to a single external evaluation unit over a req/ack handshake.
- Holds each lane's last result in a register.
- Lets one shared, stateful evaluator serve N lanes, with no concurrent-call hazard on static function storage.

---
 rtl/lane_update_pkg.sv | 49 ++++
 rtl/lane_rr_arbiter.sv | 30 +++
 rtl/lane_update_sequencer.sv | 121 ++++++++++++
 tb/tb_lane_update_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lane_update_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lane_update_pkg
//  Purpose  : Shared FSM state type and lane helpers for lane_update_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package lane_update_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } lane_state_e;

    localparam int unsigned c_MAX_LANE   = 32;
    localparam int unsigned c_MAX_LANE_W = 5;

    function automatic int unsigned lane_idx_w(input int unsigned n_lane);
        return (n_lane < 2) ? 1 : $clog2(n_lane);
    endfunction

    // Round-robin pick: first dirty lane strictly after 'last', wrapping at n_lane.
    // Returns 'last' when no lane is dirty.
    function automatic int unsigned next_lane(
        input logic [c_MAX_LANE-1:0] dirty,
        input int unsigned           last,
        input int unsigned           n_lane
    );
        int unsigned idx;
        int unsigned pick;
        bit          found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= c_MAX_LANE; k++) begin
            if (k <= n_lane) begin
                idx = last + k;
                if (idx >= n_lane) begin
                    idx = idx - n_lane;
                end
                if (!found && dirty[idx[c_MAX_LANE_W-1:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lane_rr_arbiter
//  Purpose  : Combinational round-robin selection over dirty lanes.
//  Revision : 1.0  initial release
// ============================================================================
module lane_rr_arbiter
    import lane_update_pkg::*;
#(
    parameter int unsigned N_LANE = 5
) (
    input  logic [N_LANE-1:0]               i_dirty,
    input  logic [lane_idx_w(N_LANE)-1:0]   i_last_served,
    output logic [lane_idx_w(N_LANE)-1:0]   o_grant,
    output logic                            o_any
);

    localparam int unsigned LANE_W = lane_idx_w(N_LANE);

    logic [c_MAX_LANE-1:0] w_dirty_ext;

    always_comb begin
        w_dirty_ext              = '0;
        w_dirty_ext[N_LANE-1:0]  = i_dirty;
        o_grant = LANE_W'(next_lane(w_dirty_ext, 32'(i_last_served), N_LANE));
        o_any   = |i_dirty;
    end

endmodule
`default_nettype wire

// File: rtl/lane_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lane_update_sequencer
//  Purpose  : Serves changed lanes one at a time through a shared req/ack
//             evaluator and keeps each lane's last result registered.
//  Revision : 1.0  initial release
// ============================================================================
module lane_update_sequencer
    import lane_update_pkg::*;
#(
    parameter int unsigned N_LANE = 5,
    parameter int unsigned W_IN   = 1,
    parameter int unsigned W_OUT  = 1
) (
    input  logic                            i_clk,
    input  logic                            i_arstn,
    input  logic [N_LANE*W_IN-1:0]          i_x,
    output logic [N_LANE*W_OUT-1:0]         o_c,
    output logic [N_LANE-1:0]               o_valid,
    output logic                            o_busy,
    output logic                            o_req,
    output logic [lane_idx_w(N_LANE)-1:0]   o_reqLane,
    output logic [W_IN-1:0]                 o_reqX,
    input  logic                            i_ack,
    input  logic [W_OUT-1:0]                i_result
);

    localparam int unsigned LANE_W = lane_idx_w(N_LANE);

    lane_state_e                r_state;
    lane_state_e                w_state_next;
    logic                       w_capture;
    logic                       w_complete;

    logic [N_LANE*W_OUT-1:0]    r_c;
    logic [N_LANE-1:0]          r_valid;
    logic [N_LANE*W_IN-1:0]     r_x_used;
    logic [LANE_W-1:0]          r_last_served;
    logic [LANE_W-1:0]          r_req_lane;
    logic [W_IN-1:0]            r_req_x;

    logic [N_LANE-1:0]          w_dirty;
    logic [LANE_W-1:0]          w_grant;
    logic                       w_any;

    // A lane is dirty until it has a result for exactly its current input.
    for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane
        assign w_dirty[gi] = !r_valid[gi] |
                             (i_x[gi*W_IN +: W_IN] != r_x_used[gi*W_IN +: W_IN]);
    end

    lane_rr_arbiter #(
        .N_LANE        (N_LANE)
    ) u_arb (
        .i_dirty       (w_dirty),
        .i_last_served (r_last_served),
        .o_grant       (w_grant),
        .o_any         (w_any)
    );

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_capture    = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (i_ack) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_c           <= '0;
            r_valid       <= '0;
            r_x_used      <= '0;
            r_last_served <= LANE_W'(N_LANE - 1);
            r_req_lane    <= '0;
            r_req_x       <= '0;
        end else begin
            if (w_capture) begin
                r_req_lane <= w_grant;
                r_req_x    <= i_x[w_grant*W_IN +: W_IN];
            end
            // Commit the captured input, not the live one, so a change during REQ re-dirties the lane.
            if (w_complete) begin
                r_c[r_req_lane*W_OUT +: W_OUT]     <= i_result;
                r_x_used[r_req_lane*W_IN +: W_IN]  <= r_req_x;
                r_valid[r_req_lane]                <= 1'b1;
                r_last_served                      <= r_req_lane;
            end
        end
    end

    assign o_c       = r_c;
    assign o_valid   = r_valid;
    assign o_req     = (r_state == REQ);
    assign o_reqLane = r_req_lane;
    assign o_reqX    = r_req_x;
    assign o_busy    = (r_state == REQ) | (|w_dirty);

endmodule
`default_nettype wire

// File: tb/tb_lane_update_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lane_update_sequencer
//  Purpose  : Directed self-checking bench for lane_update_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lane_update_sequencer;

    localparam int unsigned N_LANE = 5;
    localparam int unsigned W_IN   = 1;
    localparam int unsigned W_OUT  = 3;

    logic                       clk;
    logic                       rst_n;
    logic [N_LANE*W_IN-1:0]     x;
    logic [N_LANE*W_OUT-1:0]    c;
    logic [N_LANE-1:0]          valid;
    logic                       busy;
    logic                       req;
    logic [2:0]                 req_lane;
    logic [W_IN-1:0]            req_x;
    logic                       ack;
    logic [W_OUT-1:0]           result;
    logic                       inv_mode;

    int n_pass  = 0;
    int n_total = 0;

    lane_update_sequencer #(
        .N_LANE    (N_LANE),
        .W_IN      (W_IN),
        .W_OUT     (W_OUT)
    ) dut (
        .i_clk     (clk),
        .i_arstn   (rst_n),
        .i_x       (x),
        .o_c       (c),
        .o_valid   (valid),
        .o_busy    (busy),
        .o_req     (req),
        .o_reqLane (req_lane),
        .o_reqX    (req_x),
        .i_ack     (ack),
        .i_result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Evaluator responder: lane+1 during bring-up, inverted input afterwards.
    assign result = inv_mode ? {2'b00, ~req_x} : (req_lane + 3'd1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        x        = '0;
        ack      = 1'b1;
        inv_mode = 1'b0;
        tick();
        tick();
        chk("rst_req",   32'(req),      32'd0);
        chk("rst_valid", 32'(valid),    32'd0);
        chk("rst_c",     32'(c),        32'd0);
        chk("rst_lane",  32'(req_lane), 32'd0);
        chk("rst_reqx",  32'(req_x),    32'd0);

        // Bring-up: lanes 0..4 served on odd cycles after release.
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bring_req",  32'(req),      32'd1);
            chk("bring_lane", 32'(req_lane), 32'(k));
            tick();
            chk("bring_gap",  32'(req),      32'd0);
        end
        chk("bring_valid", 32'(valid), 32'h1f);
        chk("bring_c",     32'(c),     32'({3'd5, 3'd4, 3'd3, 3'd2, 3'd1}));
        chk("bring_busy",  32'(busy),  32'd0);
        tick();
        chk("idle_req",    32'(req),   32'd0);

        // Single lane change, inverting evaluator.
        inv_mode = 1'b1;
        x[2]     = 1'b1;
        #1;
        chk("l2_busy", 32'(busy), 32'd1);
        tick();
        chk("l2_req",  32'(req),      32'd1);
        chk("l2_lane", 32'(req_lane), 32'd2);
        chk("l2_x",    32'(req_x),    32'd1);
        tick();
        chk("l2_c",    32'(c),     32'({3'd5, 3'd4, 3'd0, 3'd2, 3'd1}));
        chk("l2_done", 32'(req),   32'd0);
        chk("l2_idle", 32'(busy),  32'd0);

        // Lane 3 with delayed ack and input change mid-request.
        ack  = 1'b0;
        x[3] = 1'b1;
        tick();
        chk("l3_req",  32'(req),      32'd1);
        chk("l3_lane", 32'(req_lane), 32'd3);
        chk("l3_x",    32'(req_x),    32'd1);
        x[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("l3_hold_req", 32'(req),   32'd1);
            chk("l3_hold_x",   32'(req_x), 32'd1);
        end
        ack = 1'b1;
        tick();
        chk("l3_c1",   32'(c),    32'({3'd5, 3'd0, 3'd0, 3'd2, 3'd1}));
        chk("l3_busy", 32'(busy), 32'd1);
        tick();
        chk("l3_req2",  32'(req),      32'd1);
        chk("l3_lane2", 32'(req_lane), 32'd3);
        chk("l3_x2",    32'(req_x),    32'd0);
        tick();
        chk("l3_c2",   32'(c),    32'({3'd5, 3'd1, 3'd0, 3'd2, 3'd1}));
        chk("l3_idle", 32'(busy), 32'd0);

        // Make lane 2 the last served, then dirty lanes 1 and 4 together.
        x[2] = 1'b0;
        tick();
        chk("ls2_lane", 32'(req_lane), 32'd2);
        tick();
        chk("ls2_c", 32'(c), 32'({3'd5, 3'd1, 3'd1, 3'd2, 3'd1}));
        x[1] = 1'b1;
        x[4] = 1'b1;
        tick();
        chk("rr_first", 32'(req_lane), 32'd4);
        tick();
        tick();
        chk("rr_second", 32'(req_lane), 32'd1);
        chk("rr_req",    32'(req),      32'd1);
        tick();
        chk("rr_c",    32'(c),    32'({3'd0, 3'd1, 3'd1, 3'd0, 3'd1}));
        chk("rr_busy", 32'(busy), 32'd0);

        // Return lane 1 to 0, then toggle it 0->1->0 inside lane 0's request.
        x[1] = 1'b0;
        tick();
        chk("l1_lane", 32'(req_lane), 32'd1);
        tick();
        ack  = 1'b0;
        x[0] = 1'b1;
        tick();
        chk("gl_lane", 32'(req_lane), 32'd0);
        x[1] = 1'b1;
        tick();
        x[1] = 1'b0;
        tick();
        chk("gl_hold", 32'(req_lane), 32'd0);
        ack = 1'b1;
        tick();
        chk("gl_c",    32'(c),    32'({3'd0, 3'd1, 3'd1, 3'd1, 3'd0}));
        chk("gl_busy", 32'(busy), 32'd0);
        tick();
        chk("gl_noreq", 32'(req), 32'd0);

        // Asynchronous reset while lane 3 is requesting.
        ack  = 1'b0;
        x[3] = 1'b1;
        tick();
        chk("ar_req",  32'(req),      32'd1);
        chk("ar_lane", 32'(req_lane), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req_drop", 32'(req),   32'd0);
        chk("ar_valid",    32'(valid), 32'd0);
        chk("ar_c",        32'(c),     32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_first_req",  32'(req),      32'd1);
        chk("ar_first_lane", 32'(req_lane), 32'd0);
        chk("ar_first_x",    32'(req_x),    32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
